fft_sdf_ctrl: RTL and testbench

FFT_SDF_CTRL -- requirements
Module: fft_sdf_ctrl

---
 rtl/fft_sdf_ctrl_pkg.sv | 23 ++
 rtl/fft_tw_addr_gen.sv | 25 ++
 rtl/fft_sdf_ctrl.sv | 146 ++++++++++++++
 tb/tb_fft_sdf_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fft_sdf_ctrl_pkg.sv
// ============================================================================
// Module      : fft_sdf_ctrl_pkg
// Description : Shared constants and state encoding for the SDF stage controller
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fft_sdf_ctrl_pkg;

    localparam int FFT_N     = 64;
    localparam int FFT_LOG2N = 6;
    localparam int TW_W      = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/fft_tw_addr_gen.sv
// ============================================================================
// Module      : fft_tw_addr_gen
// Description : Twiddle ROM index k*(32/DELAY) for the stage difference output
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_tw_addr_gen
    import fft_sdf_ctrl_pkg::*;
#(
    parameter int DELAY = 32
) (
    input  logic [TW_W-1:0] k,
    input  logic            en,
    output logic [TW_W-1:0] tw_addr
);

    localparam int c_SHIFT = FFT_LOG2N - 1 - $clog2(DELAY);

    // k < DELAY, so the shift never loses significant bits
    assign tw_addr = en ? TW_W'(k << c_SHIFT) : '0;

endmodule

`default_nettype wire

// File: rtl/fft_sdf_ctrl.sv
// ============================================================================
// Module      : fft_sdf_ctrl
// Description : Radix-2 SDF stage controller (fill / butterfly / drain).
//               Twiddle addressing enabled by FFT_SDF_CTRL_TWIDDLE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_sdf_ctrl
    import fft_sdf_ctrl_pkg::*;
#(
    parameter int DELAY = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            fifo_w_en,
    output logic            fifo_r_en,
    output logic            bf_mode,
    output logic [TW_W-1:0] tw_addr,
    output logic            out_valid,
    output logic            out_last,
    output logic            busy,
    output logic            err
);

    localparam logic [FFT_LOG2N-1:0] c_MASK      = FFT_LOG2N'(DELAY - 1);
    localparam logic [TW_W-1:0]      c_DRAIN_END = TW_W'(DELAY - 1);
    localparam logic [FFT_LOG2N:0]   c_RD_START  = (FFT_LOG2N + 1)'(2 * DELAY);

    state_t                 r_state;
    state_t                 w_next;
    logic [FFT_LOG2N-1:0]   r_cnt;
    logic [TW_W-1:0]        r_dcnt;
    logic                   r_err;
    logic                   w_blk_end;
    logic                   w_fill_rd;
    logic                   w_drain_end;
    logic                   w_accept;

    assign w_blk_end   = (r_cnt & c_MASK) == c_MASK;
    assign w_fill_rd   = {1'b0, r_cnt} >= c_RD_START;
    assign w_drain_end = r_dcnt == c_DRAIN_END;
    assign w_accept    = in_valid && (r_state != DRAIN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dcnt  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == DRAIN) begin
                r_dcnt <= w_drain_end ? '0 : r_dcnt + 1'b1;
                if (in_valid) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        fifo_w_en = 1'b0;
        fifo_r_en = 1'b0;
        bf_mode   = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        err       = 1'b0;
        case (r_state)
            // The sample that wakes the stage is frame sample 0 and is written now
            IDLE: begin
                fifo_w_en = in_valid;
                if (in_valid) begin
                    w_next = w_blk_end ? COMPUTE : FILL;
                end
            end
            FILL: begin
                fifo_w_en = in_valid;
                fifo_r_en = w_fill_rd;
                out_valid = w_fill_rd && in_valid;
                busy      = 1'b1;
                if (in_valid && w_blk_end) begin
                    w_next = COMPUTE;
                end
            end
            COMPUTE: begin
                fifo_w_en = in_valid;
                fifo_r_en = 1'b1;
                bf_mode   = 1'b1;
                out_valid = in_valid;
                busy      = 1'b1;
                if (in_valid && w_blk_end) begin
                    w_next = (r_cnt == FFT_LOG2N'(FFT_N - 1)) ? DRAIN : FILL;
                end
            end
            DRAIN: begin
                fifo_w_en = 1'b1;
                fifo_r_en = 1'b1;
                out_valid = 1'b1;
                out_last  = w_drain_end;
                busy      = 1'b1;
                if (w_drain_end) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
        err = r_err;
        if (!rst_n) begin
            fifo_w_en = 1'b0;
            fifo_r_en = 1'b0;
            bf_mode   = 1'b0;
            out_valid = 1'b0;
            out_last  = 1'b0;
            busy      = 1'b0;
            err       = 1'b0;
        end
    end

`ifdef FFT_SDF_CTRL_TWIDDLE_EN
    logic [TW_W-1:0] w_k;
    logic            w_tw_en;

    assign w_k     = (r_state == DRAIN) ? r_dcnt : (r_cnt[TW_W-1:0] & c_MASK[TW_W-1:0]);
    assign w_tw_en = rst_n && ((r_state == DRAIN) || ((r_state == FILL) && w_fill_rd));

    fft_tw_addr_gen #(
        .DELAY   (DELAY)
    ) u_tw_addr_gen (
        .k       (w_k),
        .en      (w_tw_en),
        .tw_addr (tw_addr)
    );
`else
    assign tw_addr = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fft_sdf_ctrl.sv
// ============================================================================
// Module      : tb_fft_sdf_ctrl
// Description : Directed bench for fft_sdf_ctrl at DELAY = 32, 8 and 4
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_sdf_ctrl;

`ifdef FFT_SDF_CTRL_TWIDDLE_EN
    localparam bit c_TW_ON = 1'b1;
`else
    localparam bit c_TW_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rn [3];
    logic       iv [3];
    logic       fw [3];
    logic       fr [3];
    logic       bm [3];
    logic       ov [3];
    logic       ol [3];
    logic       bz [3];
    logic       er [3];
    logic [4:0] tw [3];

    int n_checks = 0;
    int n_errors = 0;
    int sel      = 0;
    int n_out    = 0;
    bit exp_err [3];

    always #5 clk = ~clk;

    fft_sdf_ctrl #(.DELAY(32)) u_dut32 (
        .clk(clk), .rst_n(rn[0]), .in_valid(iv[0]), .fifo_w_en(fw[0]), .fifo_r_en(fr[0]),
        .bf_mode(bm[0]), .tw_addr(tw[0]), .out_valid(ov[0]), .out_last(ol[0]),
        .busy(bz[0]), .err(er[0]));

    fft_sdf_ctrl #(.DELAY(8)) u_dut8 (
        .clk(clk), .rst_n(rn[1]), .in_valid(iv[1]), .fifo_w_en(fw[1]), .fifo_r_en(fr[1]),
        .bf_mode(bm[1]), .tw_addr(tw[1]), .out_valid(ov[1]), .out_last(ol[1]),
        .busy(bz[1]), .err(er[1]));

    fft_sdf_ctrl #(.DELAY(4)) u_dut4 (
        .clk(clk), .rst_n(rn[2]), .in_valid(iv[2]), .fifo_w_en(fw[2]), .fifo_r_en(fr[2]),
        .bf_mode(bm[2]), .tw_addr(tw[2]), .out_valid(ov[2]), .out_last(ol[2]),
        .busy(bz[2]), .err(er[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (dut %0d, t=%0t)", tag, got, exp, sel, $time);
        end
    endtask

    function automatic int dly();
        case (sel)
            0:       return 32;
            1:       return 8;
            default: return 4;
        endcase
    endfunction

    // Odd blocks of the frame are butterfly blocks
    function automatic bit exp_bf(input int i);
        return ((i / dly()) % 2) == 1;
    endfunction

    function automatic bit exp_rd(input int i);
        return exp_bf(i) || (i >= 2 * dly());
    endfunction

    function automatic int exp_tw(input int k, input bit en);
        return (en && c_TW_ON) ? k * (32 / dly()) : 0;
    endfunction

    task automatic check_outs(input string tag, input bit w, input bit r, input bit b,
                              input bit o, input bit l, input bit z, input int t);
        check({tag, ".fifo_w_en"}, fw[sel], w);
        check({tag, ".fifo_r_en"}, fr[sel], r);
        check({tag, ".bf_mode"},   bm[sel], b);
        check({tag, ".out_valid"}, ov[sel], o);
        check({tag, ".out_last"},  ol[sel], l);
        check({tag, ".busy"},      bz[sel], z);
        check({tag, ".tw_addr"},   tw[sel], t);
    endtask

    task automatic cyc(input bit v);
        @(negedge clk);
        iv[sel] = v;
        #2;
        if (rn[sel]) check("err", er[sel], exp_err[sel]);
    endtask

    task automatic sample(input int i, input bit gap);
        bit rd;
        bit bf;
        rd = exp_rd(i);
        bf = exp_bf(i);
        if (gap) begin
            cyc(1'b0);
            check_outs("gap", 1'b0, rd, bf, 1'b0, 1'b0, i > 0, exp_tw(i % dly(), !bf && rd));
        end
        cyc(1'b1);
        check_outs("smp", 1'b1, rd, bf, rd, 1'b0, i > 0, exp_tw(i % dly(), !bf && rd));
        if (ov[sel]) n_out++;
    endtask

    task automatic drain(input int err_at);
        for (int d = 0; d < dly(); d++) begin
            cyc(d == err_at);
            check_outs("drn", 1'b1, 1'b1, 1'b0, 1'b1, d == dly() - 1, 1'b1, exp_tw(d, 1'b1));
            if (ov[sel]) n_out++;
            if (d == err_at) exp_err[sel] = 1'b1;
        end
    endtask

    task automatic frame(input bit gap, input int err_at);
        n_out = 0;
        for (int i = 0; i < 64; i++) sample(i, gap);
        drain(err_at);
        check("n_out", n_out, 64);
        cyc(1'b0);
        check_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            rn[s]      = 1'b0;
            iv[s]      = 1'b1;
            exp_err[s] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check_outs("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
            check("rst.err", er[sel], 0);
        end
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            rn[s] = 1'b1;
            iv[s] = 1'b0;
        end

        sel = 0;
        frame(1'b0, -1);
        frame(1'b0, -1);

        sel = 1;
        frame(1'b0, -1);
        frame(1'b0, 2);
        frame(1'b0, -1);

        // Mid-frame reset at sample 40 abandons the frame and clears err
        for (int i = 0; i < 40; i++) sample(i, 1'b0);
        @(negedge clk);
        rn[1] = 1'b0;
        iv[1] = 1'b1;
        #2;
        check_outs("mrst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("mrst.err", er[1], 0);
        @(negedge clk);
        rn[1]      = 1'b1;
        iv[1]      = 1'b0;
        exp_err[1] = 1'b0;
        #2;
        check_outs("post", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("post.err", er[1], 0);
        frame(1'b0, -1);

        sel = 2;
        frame(1'b1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
